// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the pipelined main control unit.
// Holds opcode constants, control field encodings, the 16-bit control
// bundle layout and the branch func3 maps for both BR_ENC settings.
package ctrl_pkg;

    // Opcodes recognised by the decoder
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_R = 2'b10, ALU_I = 2'b11
    } aluop_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
    } imm_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_IMM = 2'b11
    } res_t;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00, JMP_JAL = 2'b01, JMP_JALR = 2'b10
    } jump_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000, BR_BEQ = 3'b001, BR_BNE = 3'b010, BR_BLT = 3'b011,
        BR_BGE  = 3'b100, BR_BLTU = 3'b101, BR_BGEU = 3'b110
    } branch_t;

    // Bundle layout, MSB first; the packed struct below must agree with these offsets
    localparam int CTRL_W     = 16;
    localparam int LUI_BIT    = 0;
    localparam int BRANCH_LSB = 1;
    localparam int JUMP_LSB   = 4;
    localparam int RES_LSB    = 6;
    localparam int MEMW_BIT   = 8;
    localparam int ALUSRC_BIT = 9;
    localparam int IMM_LSB    = 10;
    localparam int REGW_BIT   = 13;
    localparam int ALUOP_LSB  = 14;

    typedef struct packed {
        aluop_t  aluop;
        logic    regwrite;
        imm_t    immsrc;
        logic    alusrc;
        logic    memwrite;
        res_t    resultsrc;
        jump_t   jump;
        branch_t branch;
        logic    lui;
    } ctrl_t;

    // Branch func3 maps
    localparam int BR_ENC_LEGACY = 0;
    localparam int BR_ENC_RISCV  = 1;

    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [2:0] F3L_BLT   = 3'b010;
    localparam logic [2:0] F3L_BGE   = 3'b011;
    localparam logic [2:0] F3R_BLT   = 3'b100;
    localparam logic [2:0] F3R_BGE   = 3'b101;
    localparam logic [2:0] F3R_BLTU  = 3'b110;
    localparam logic [2:0] F3R_BGEU  = 3'b111;
    localparam logic [2:0] F3_LW     = 3'b010;
    localparam logic [2:0] F3_JALR   = 3'b000;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational op/func3 decoder for the D stage.
// Ports: op, func3, instr_valid in; ctrlD (16-bit bundle) and illegalD out.
// Illegal or non-valid instructions produce an all-zero bundle (a bubble).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int BR_ENC     = 1,
    parameter int EXT_BRANCH = 1
) (
    input  logic [6:0]        op,
    input  logic [2:0]        func3,
    input  logic              instr_valid,
    output logic [CTRL_W-1:0] ctrlD,
    output logic              illegalD
);

    ctrl_t c;
    logic  ill;

    always_comb begin
        c   = '0;
        ill = 1'b0;
        unique case (op)
            OP_R: begin
                c.aluop    = ALU_R;
                c.regwrite = 1'b1;
            end
            OP_I: begin
                c.aluop    = ALU_I;
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
            end
            OP_S: begin
                c.memwrite = 1'b1;
                c.immsrc   = IMM_S;
                c.alusrc   = 1'b1;
            end
            OP_B: begin
                c.aluop  = ALU_BR;
                c.immsrc = IMM_B;
                if (BR_ENC == BR_ENC_LEGACY) begin
                    case (func3)
                        F3_BEQ:  c.branch = BR_BEQ;
                        F3_BNE:  c.branch = BR_BNE;
                        F3L_BLT: c.branch = BR_BLT;
                        F3L_BGE: c.branch = BR_BGE;
                        default: ill = 1'b1;
                    endcase
                end else begin
                    case (func3)
                        F3_BEQ:   c.branch = BR_BEQ;
                        F3_BNE:   c.branch = BR_BNE;
                        F3R_BLT:  c.branch = BR_BLT;
                        F3R_BGE:  c.branch = BR_BGE;
                        F3R_BLTU: if (EXT_BRANCH != 0) c.branch = BR_BLTU; else ill = 1'b1;
                        F3R_BGEU: if (EXT_BRANCH != 0) c.branch = BR_BGEU; else ill = 1'b1;
                        default:  ill = 1'b1;
                    endcase
                end
            end
            OP_LUI: begin
                c.resultsrc = RES_IMM;
                c.immsrc    = IMM_U;
                c.regwrite  = 1'b1;
                c.lui       = 1'b1;
            end
            OP_JAL: begin
                c.resultsrc = RES_PC4;
                c.immsrc    = IMM_J;
                c.jump      = JMP_JAL;
                c.regwrite  = 1'b1;
            end
            OP_LW: begin
                c.regwrite  = 1'b1;
                c.alusrc    = 1'b1;
                c.resultsrc = RES_MEM;
                ill         = (func3 != F3_LW);
            end
            OP_JALR: begin
                c.regwrite  = 1'b1;
                c.alusrc    = 1'b1;
                c.jump      = JMP_JALR;
                c.resultsrc = RES_PC4;
                ill         = (func3 != F3_JALR);
            end
            default: ill = 1'b1;
        endcase
    end

    // Only a real instruction can be illegal; anything not cleanly decoded becomes a bubble
    assign illegalD = instr_valid & ill;
    assign ctrlD    = (instr_valid && !ill) ? c : '0;

endmodule

// File: rtl/main_control_pipe.sv
// main_control_pipe: D-stage decode plus E/M/W control pipeline registers.
// Ports: clk, rst (sync, active-high), instr_valid/op/func3 (D stage),
// stallE/flushE from the hazard unit; ctrlD/illegalD (combinational D),
// ctrlE/illegalE (E), regWriteM/memWriteM/resultSrcM (M),
// regWriteW/resultSrcW (W), illegal_cnt (saturating illegal count).
module main_control_pipe
    import ctrl_pkg::*;
#(
    parameter int BR_ENC     = 1,
    parameter int EXT_BRANCH = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [6:0]        op,
    input  logic [2:0]        func3,
    input  logic              stallE,
    input  logic              flushE,
    output logic [CTRL_W-1:0] ctrlD,
    output logic              illegalD,
    output logic [CTRL_W-1:0] ctrlE,
    output logic              illegalE,
    output logic              regWriteM,
    output logic              memWriteM,
    output logic [1:0]        resultSrcM,
    output logic              regWriteW,
    output logic [1:0]        resultSrcW,
    output logic [CNT_W-1:0]  illegal_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    ctrl_decode #(
        .BR_ENC     (BR_ENC),
        .EXT_BRANCH (EXT_BRANCH)
    ) u_decode (
        .op          (op),
        .func3       (func3),
        .instr_valid (instr_valid),
        .ctrlD       (ctrlD),
        .illegalD    (illegalD)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlE       <= '0;
            illegalE    <= 1'b0;
            regWriteM   <= 1'b0;
            memWriteM   <= 1'b0;
            resultSrcM  <= 2'b00;
            regWriteW   <= 1'b0;
            resultSrcW  <= 2'b00;
            illegal_cnt <= '0;
        end else begin
            // D -> E: flush beats stall
            if (flushE) begin
                ctrlE    <= '0;
                illegalE <= 1'b0;
            end else if (!stallE) begin
                ctrlE    <= ctrlD;
                illegalE <= illegalD;
            end
            // E -> M
            regWriteM  <= ctrlE[REGW_BIT];
            memWriteM  <= ctrlE[MEMW_BIT];
            resultSrcM <= ctrlE[RES_LSB +: 2];
            // M -> W
            regWriteW  <= regWriteM;
            resultSrcW <= resultSrcM;
            // Count only on the edge that actually moves the instruction into E,
            // so a stalled instruction counts once and a flushed one never does
            if (illegalD && !stallE && !flushE)
                illegal_cnt <= sat_inc(illegal_cnt);
        end
    end

endmodule

// File: tb/tb_main_control_pipe.sv
// Testbench for main_control_pipe: four instances with different parameter
// sets share one stimulus stream and are compared to a behavioural model.
module tb_main_control_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, instr_valid, stallE, flushE;
    logic [6:0] op;
    logic [2:0] func3;

    logic [15:0] ctrlD_a[4], ctrlE_a[4];
    logic        illD_a[4], illE_a[4], regM_a[4], memM_a[4], regW_a[4];
    logic [1:0]  resM_a[4], resW_a[4];
    logic [7:0]  cnt_a[3];
    logic [1:0]  cnt3;

    // Instances 0..2: {BR_ENC,EXT_BRANCH} = {1,1}, {1,0}, {0,1}; CNT_W = 8
    for (genvar g = 0; g < 3; g++) begin : g_dut
        main_control_pipe #(
            .BR_ENC     ((g == 2) ? 0 : 1),
            .EXT_BRANCH ((g == 1) ? 0 : 1),
            .CNT_W      (8)
        ) u_dut (
            .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op), .func3(func3),
            .stallE(stallE), .flushE(flushE),
            .ctrlD(ctrlD_a[g]), .illegalD(illD_a[g]), .ctrlE(ctrlE_a[g]), .illegalE(illE_a[g]),
            .regWriteM(regM_a[g]), .memWriteM(memM_a[g]), .resultSrcM(resM_a[g]),
            .regWriteW(regW_a[g]), .resultSrcW(resW_a[g]), .illegal_cnt(cnt_a[g])
        );
    end

    // Instance 3: default decode, 2-bit counter
    main_control_pipe #(.BR_ENC(1), .EXT_BRANCH(1), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op), .func3(func3),
        .stallE(stallE), .flushE(flushE),
        .ctrlD(ctrlD_a[3]), .illegalD(illD_a[3]), .ctrlE(ctrlE_a[3]), .illegalE(illE_a[3]),
        .regWriteM(regM_a[3]), .memWriteM(memM_a[3]), .resultSrcM(resM_a[3]),
        .regWriteW(regW_a[3]), .resultSrcW(resW_a[3]), .illegal_cnt(cnt3)
    );

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    logic [15:0] mE[4];
    bit          mIllE[4], mRegM[4], mMemM[4], mRegW[4];
    logic [1:0]  mResM[4], mResW[4];
    int          mCnt[4];

    function automatic int br_enc_of(int i); return (i == 2) ? 0 : 1; endfunction
    function automatic int ext_of(int i);    return (i == 1) ? 0 : 1; endfunction
    function automatic int cmax_of(int i);   return (i == 3) ? 3 : 255; endfunction

    function automatic logic [31:0] cnt_of(int i);
        return (i == 3) ? 32'(cnt3) : 32'(cnt_a[i]);
    endfunction

    // Branch code from func3; 0 means unmapped
    function automatic logic [2:0] branch_code(int i, logic [2:0] f3);
        if (br_enc_of(i) == 0)
            return (f3 < 3'd4) ? f3 + 3'd1 : 3'd0;
        case (f3)
            3'd0: return 3'd1;
            3'd1: return 3'd2;
            3'd4: return 3'd3;
            3'd5: return 3'd4;
            3'd6: return (ext_of(i) != 0) ? 3'd5 : 3'd0;
            3'd7: return (ext_of(i) != 0) ? 3'd6 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction

    task automatic ref_decode(input int i, input logic [6:0] o, input logic [2:0] f3,
                              input bit v, output logic [15:0] c, output bit ill);
        logic [1:0] aluop = 0, res = 0, jmp = 0;
        logic [2:0] imm = 0, br = 0;
        bit rw = 0, asrc = 0, mw = 0, lui = 0;
        ill = 0;
        case (o)
            7'b0110011: begin aluop = 2; rw = 1; end
            7'b0010011: begin aluop = 3; rw = 1; asrc = 1; end
            7'b0100011: begin mw = 1; imm = 1; asrc = 1; end
            7'b1100011: begin aluop = 1; imm = 2; br = branch_code(i, f3); ill = (br == 0); end
            7'b0110111: begin res = 3; imm = 4; rw = 1; lui = 1; end
            7'b1101111: begin res = 2; imm = 3; jmp = 1; rw = 1; end
            7'b0000011: begin rw = 1; asrc = 1; res = 1; ill = (f3 != 3'b010); end
            7'b1100111: begin rw = 1; asrc = 1; jmp = 2; res = 2; ill = (f3 != 3'b000); end
            default: ill = 1;
        endcase
        ill = ill && v;
        c = (v && !ill) ? {aluop, rw, imm, asrc, mw, res, jmp, br, lui} : 16'h0;
    endtask

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s[%0d]: got %0h expected %0h (t=%0t)", nm, i, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [15:0] c;
        bit ill;
        for (int i = 0; i < 4; i++) begin
            ref_decode(i, op, func3, instr_valid, c, ill);
            chk("ctrlD", i, 32'(ctrlD_a[i]), 32'(c));
            chk("illegalD", i, 32'(illD_a[i]), 32'(ill));
            chk("ctrlE", i, {15'b0, illE_a[i], ctrlE_a[i]}, {15'b0, mIllE[i], mE[i]});
            chk("stageM", i, 32'({regM_a[i], memM_a[i], resM_a[i]}), 32'({mRegM[i], mMemM[i], mResM[i]}));
            chk("stageW", i, 32'({regW_a[i], resW_a[i]}), 32'({mRegW[i], mResW[i]}));
            chk("illegal_cnt", i, cnt_of(i), 32'(mCnt[i]));
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input bit v,
                         input bit st, input bit fl, input bit r);
        op = o; func3 = f3; instr_valid = v; stallE = st; flushE = fl; rst = r;
        #3;
    endtask

    // Advance one clock edge and move the model along with it
    task automatic tick();
        logic [15:0] c;
        bit ill;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mE[i] = 0; mIllE[i] = 0; mRegM[i] = 0; mMemM[i] = 0; mResM[i] = 0;
                mRegW[i] = 0; mResW[i] = 0; mCnt[i] = 0;
            end else begin
                ref_decode(i, op, func3, instr_valid, c, ill);
                mRegW[i] = mRegM[i];
                mResW[i] = mResM[i];
                mRegM[i] = mE[i][13];
                mMemM[i] = mE[i][8];
                mResM[i] = mE[i][7:6];
                if (ill && !stallE && !flushE && mCnt[i] < cmax_of(i)) mCnt[i]++;
                if (flushE) begin
                    mE[i] = 0; mIllE[i] = 0;
                end else if (!stallE) begin
                    mE[i] = c; mIllE[i] = ill;
                end
            end
        end
        #1;
    endtask

    // step: drive, compare everything against the model, then clock
    task automatic step(input logic [6:0] o, input logic [2:0] f3, input bit v,
                        input bit st, input bit fl, input bit r);
        drive(o, f3, v, st, fl, r);
        check_all();
        tick();
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          v;
        logic [15:0] c0, c1, c2;
        bit          i0, i1, i2;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [6:0] o, input logic [2:0] f3, input bit v,
                       input logic [15:0] c0, input bit i0, input logic [15:0] c1, input bit i1,
                       input logic [15:0] c2, input bit i2);
        vec_t e;
        e.op = o; e.f3 = f3; e.v = v;
        e.c0 = c0; e.c1 = c1; e.c2 = c2; e.i0 = i0; e.i1 = i1; e.i2 = i2;
        tbl.push_back(e);
    endtask

    initial begin
        logic [6:0] ops[9];
        logic [6:0] ro;
        int k;
        ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b1101111, 7'b0000011, 7'b1100111, 7'b1111111};
        for (int i = 0; i < 4; i++) begin
            mE[i] = 0; mIllE[i] = 0; mRegM[i] = 0; mMemM[i] = 0; mResM[i] = 0;
            mRegW[i] = 0; mResW[i] = 0; mCnt[i] = 0;
        end

        // Expected bundles for instances 0 (RISC-V+ext), 1 (RISC-V, no ext), 2 (legacy)
        add(7'b0110011, 3'd0, 1, 16'hA000, 0, 16'hA000, 0, 16'hA000, 0);
        add(7'b0110011, 3'd0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
        add(7'b0010011, 3'd5, 1, 16'hE200, 0, 16'hE200, 0, 16'hE200, 0);
        add(7'b0100011, 3'd2, 1, 16'h0700, 0, 16'h0700, 0, 16'h0700, 0);
        add(7'b1100011, 3'd0, 1, 16'h4802, 0, 16'h4802, 0, 16'h4802, 0);
        add(7'b1100011, 3'd1, 1, 16'h4804, 0, 16'h4804, 0, 16'h4804, 0);
        add(7'b1100011, 3'd2, 1, 16'h0000, 1, 16'h0000, 1, 16'h4806, 0);
        add(7'b1100011, 3'd3, 1, 16'h0000, 1, 16'h0000, 1, 16'h4808, 0);
        add(7'b1100011, 3'd4, 1, 16'h4806, 0, 16'h4806, 0, 16'h0000, 1);
        add(7'b1100011, 3'd5, 1, 16'h4808, 0, 16'h4808, 0, 16'h0000, 1);
        add(7'b1100011, 3'd6, 1, 16'h480A, 0, 16'h0000, 1, 16'h0000, 1);
        add(7'b1100011, 3'd7, 1, 16'h480C, 0, 16'h0000, 1, 16'h0000, 1);
        add(7'b0110111, 3'd3, 1, 16'h30C1, 0, 16'h30C1, 0, 16'h30C1, 0);
        add(7'b1101111, 3'd1, 1, 16'h2C90, 0, 16'h2C90, 0, 16'h2C90, 0);
        add(7'b0000011, 3'd2, 1, 16'h2240, 0, 16'h2240, 0, 16'h2240, 0);
        add(7'b0000011, 3'd0, 1, 16'h0000, 1, 16'h0000, 1, 16'h0000, 1);
        add(7'b1100111, 3'd0, 1, 16'h22A0, 0, 16'h22A0, 0, 16'h22A0, 0);
        add(7'b1100111, 3'd1, 1, 16'h0000, 1, 16'h0000, 1, 16'h0000, 1);
        add(7'b1111111, 3'd0, 1, 16'h0000, 1, 16'h0000, 1, 16'h0000, 1);
        add(7'b1111111, 3'd0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);

        // Reset
        drive(7'b0, 3'd0, 0, 0, 0, 1);
        tick();
        tick();
        step(7'b0, 3'd0, 0, 0, 0, 1);

        // Reset then R-type walks through E, M, W
        step(7'b0110011, 3'd0, 1, 0, 0, 0);
        chk("R_ctrlE", 0, 32'(ctrlE_a[0]), 32'h0000A000);
        step(7'b0, 3'd0, 0, 0, 0, 0);
        chk("R_regWriteM", 0, 32'(regM_a[0]), 32'd1);
        step(7'b0, 3'd0, 0, 0, 0, 0);
        chk("R_regWriteW", 0, 32'(regW_a[0]), 32'd1);

        // Decode table
        foreach (tbl[n]) begin
            drive(tbl[n].op, tbl[n].f3, tbl[n].v, 0, 0, 0);
            chk("tbl_ctrlD", 0, 32'(ctrlD_a[0]), 32'(tbl[n].c0));
            chk("tbl_ctrlD", 1, 32'(ctrlD_a[1]), 32'(tbl[n].c1));
            chk("tbl_ctrlD", 2, 32'(ctrlD_a[2]), 32'(tbl[n].c2));
            chk("tbl_illD", 0, 32'(illD_a[0]), 32'(tbl[n].i0));
            chk("tbl_illD", 1, 32'(illD_a[1]), 32'(tbl[n].i1));
            chk("tbl_illD", 2, 32'(illD_a[2]), 32'(tbl[n].i2));
            check_all();
            tick();
        end

        // bltu on the no-extension instance counts as illegal
        step(7'b0, 3'd0, 0, 0, 0, 1);
        step(7'b1100011, 3'd6, 1, 0, 0, 0);
        chk("bltu_noext_cnt", 1, 32'(cnt_a[1]), 32'd1);

        // LW held by a 3-cycle stall behind an I-type
        step(7'b0, 3'd0, 0, 0, 0, 1);
        step(7'b0010011, 3'd0, 1, 0, 0, 0);
        for (int s = 0; s < 3; s++) begin
            step(7'b0000011, 3'd2, 1, 1, 0, 0);
            chk("stall_hold", 0, 32'(ctrlE_a[0]), 32'h0000E200);
        end
        step(7'b0000011, 3'd2, 1, 0, 0, 0);
        chk("stall_release", 0, 32'(ctrlE_a[0][7:6]), 32'd1);

        // Illegal op held across a 2-cycle stall counts once
        step(7'b0, 3'd0, 0, 0, 0, 1);
        step(7'b1111111, 3'd0, 1, 1, 0, 0);
        step(7'b1111111, 3'd0, 1, 1, 0, 0);
        chk("stall_ill_cnt", 0, 32'(cnt_a[0]), 32'd0);
        step(7'b1111111, 3'd0, 1, 0, 0, 0);
        step(7'b0, 3'd0, 0, 0, 0, 0);
        chk("stall_ill_cnt", 0, 32'(cnt_a[0]), 32'd1);

        // JAL flushed: never reaches M or W
        step(7'b0, 3'd0, 0, 0, 0, 1);
        step(7'b1101111, 3'd0, 1, 0, 1, 0);
        chk("flush_ctrlE", 0, 32'(ctrlE_a[0]), 32'd0);
        step(7'b0, 3'd0, 0, 0, 0, 0);
        chk("flush_regWriteM", 0, 32'(regM_a[0]), 32'd0);
        step(7'b0, 3'd0, 0, 0, 0, 0);
        chk("flush_regWriteW", 0, 32'(regW_a[0]), 32'd0);

        // 2-bit counter saturates at 3, then mid-stream reset clears everything
        step(7'b0, 3'd0, 0, 0, 0, 1);
        for (int s = 0; s < 5; s++) begin
            step(7'b1111111, 3'd0, 1, 0, 0, 0);
            chk("sat_cnt", 3, 32'(cnt3), (s < 3) ? 32'(s + 1) : 32'd3);
        end
        step(7'b0110011, 3'd0, 1, 0, 0, 0);
        step(7'b0110011, 3'd0, 1, 0, 0, 0);
        chk("pre_rst_regWriteM", 3, 32'(regM_a[3]), 32'd1);
        step(7'b0110011, 3'd0, 1, 0, 0, 1);
        chk("rst_clear", 3, {8'b0, ctrlE_a[3], illE_a[3], regM_a[3], memM_a[3],
                             resM_a[3], regW_a[3], resW_a[3], cnt3}, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            ro = (k == 9) ? 7'($urandom) : ops[k];
            step(ro, 3'($urandom), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 49) == 0));
        end
        drive(7'b0, 3'd0, 0, 0, 0, 0);
        check_all();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
